// File: rtl/fil_dout_packer.sv
// fil_dout_packer: FPGA-in-the-loop return path. Captures one DUT output
// sample per enabled cycle, packs PACK samples (lane 0 = oldest) into a word,
// queues words in a small first-word-fall-through FIFO and hands them to the
// host transmit link over valid/ready.
// Optional build macro FIL_TX_PARITY_EN adds tx_parity: per-lane XOR parity
// computed when the word is pushed and stored alongside it.

// One pack-register lane: holds the sample written while its word is filling.
module fil_dout_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);
  // Clear wins over write: the sample arriving on a push edge already went
  // into the pushed word through the bypass path in the parent.
  always_ff @(posedge clk or posedge reset)
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (wr)  q <= din;
endmodule

module fil_dout_packer #(
  parameter int DATA_W     = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enb,
  input  logic [DATA_W-1:0]        din,
  input  logic                     flush,
  output logic [DATA_W*PACK-1:0]   tx_data,
  output logic [PACK-1:0]          tx_keep,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     overflow,
  output logic [15:0]              word_count
`ifdef FIL_TX_PARITY_EN
  ,
  output logic [PACK-1:0]          tx_parity
`endif
);
  localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(PACK - 1);

  typedef struct packed {
    logic [PACK-1:0][DATA_W-1:0] data;
    logic [PACK-1:0]             keep;
`ifdef FIL_TX_PARITY_EN
    logic [PACK-1:0]             par;
`endif
  } word_t;

  logic [CW-1:0]               cnt;
  logic [PACK-1:0]             lane_wr;
  logic [PACK-1:0][DATA_W-1:0] lane_q;
  logic                        word_done;
  logic                        push;
  word_t                       push_w;

  word_t                       mem [FIFO_DEPTH];
  word_t                       head;
  logic [AW:0]                 wr_ptr;
  logic [AW:0]                 rd_ptr;
  logic                        full;
  logic                        pop;
  logic                        wr_en;

  // A word leaves the packer when the last lane fills, or on flush whenever
  // at least one sample (including one arriving this cycle) is pending. A
  // flush coinciding with the completing sample therefore yields one word.
  assign word_done = enb && (cnt == LAST);
  assign push      = word_done || (flush && (enb || (cnt != '0)));

  // Assemble the word to push: registered lanes plus the in-flight sample,
  // unfilled lanes forced to zero.
  always_comb begin
    push_w  = '0;
    lane_wr = '0;
    for (int i = 0; i < PACK; i++) begin
      lane_wr[i]     = enb && (cnt == CW'(i));
      push_w.keep[i] = (CW'(i) < cnt) || lane_wr[i];
      if (lane_wr[i])          push_w.data[i] = din;
      else if (push_w.keep[i]) push_w.data[i] = lane_q[i];
      else                     push_w.data[i] = '0;
`ifdef FIL_TX_PARITY_EN
      push_w.par[i]  = push_w.keep[i] & (^push_w.data[i]);
`endif
    end
  end

  // Lane counter: advances per sample, returns to 0 whenever a word is pushed.
  always_ff @(posedge clk or posedge reset)
    if (reset)     cnt <= '0;
    else if (push) cnt <= '0;
    else if (enb)  cnt <= cnt + CW'(1);

  for (genvar g = 0; g < PACK; g++) begin : g_lane
    fil_dout_lane #(.DATA_W(DATA_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .wr    (lane_wr[g]),
      .clr   (push),
      .din   (din),
      .q     (lane_q[g])
    );
  end

  // FIFO pointers carry one wrap bit so full and empty are distinguishable.
  assign tx_valid = (wr_ptr != rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop      = tx_valid && tx_ready;
  assign wr_en    = push && (!full || pop);

  // Word storage; when full with a simultaneous pop the write lands in the
  // slot being vacated, which is read out combinationally before the edge.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= push_w;
    end

  // Pointer update; reset clears both so tx_valid falls asynchronously.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end

  // Sticky drop flag and host-accepted word counter.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      if (push && full && !pop) overflow <= 1'b1;
      if (pop)                  word_count <= word_count + 16'd1;
    end

  // Head word is held until popped; outputs read zero while the FIFO is empty.
  assign head    = mem[rd_ptr[AW-1:0]];
  assign tx_data = tx_valid ? head.data : '0;
  assign tx_keep = tx_valid ? head.keep : '0;
`ifdef FIL_TX_PARITY_EN
  assign tx_parity = tx_valid ? head.par : '0;
`endif

endmodule
